mtr_spd_ramp: RTL and testbench



---
 rtl/mtr_spd_ramp.sv | 131 +++++++++++++
 tb/tb_mtr_spd_ramp.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mtr_spd_ramp.sv
// Slew-rate limiter and power sequencer feeding the motor driver speed words.
// Optional command deadband enabled by defining MTR_SPD_DEADBAND_EN.
module mtr_spd_ramp #(
    parameter int STEP     = 16,
    parameter int UPD_DIV  = 2048,
    parameter int DEADBAND = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pwr_up,
    input  logic signed [11:0] lft_cmd,
    input  logic signed [11:0] rght_cmd,
    input  logic               flt,
    input  logic               flt_clr,
    output logic signed [11:0] lft_spd,
    output logic signed [11:0] rght_spd,
    output logic               ramping,
    output logic               faulted
);

    localparam int CNT_W = (UPD_DIV > 1) ? $clog2(UPD_DIV) : 1;
    localparam logic signed [12:0] STEP13 = 13'(STEP);
    localparam logic signed [11:0] STEP12 = 12'(STEP);
    localparam logic [11:0]        DB_MAG = 12'(DEADBAND);
`ifdef MTR_SPD_DEADBAND_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP, S_FAULT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [11:0] lft_q, lft_d, rght_q, rght_d;
    logic signed [11:0] tgt_l, tgt_r, slew_l, slew_r;
    logic               tick;

    // Ones-complement magnitude keeps -2048 representable in 12 bits.
    function automatic logic signed [11:0] dead_band(input logic signed [11:0] c);
        logic [11:0] mag;
        mag = c[11] ? ~c : c;
        return (DB_EN && (mag < DB_MAG)) ? 12'sd0 : c;
    endfunction

    function automatic logic signed [11:0] slew(input logic signed [11:0] cur,
                                                input logic signed [11:0] tgt);
        logic signed [12:0] diff;
        diff = {tgt[11], tgt} - {cur[11], cur};
        if (diff > STEP13)
            return cur + STEP12;
        else if (diff < -STEP13)
            return cur - STEP12;
        else
            return tgt;
    endfunction

    assign tick  = (cnt_q == CNT_W'(UPD_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lft_q   <= '0;
            rght_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
        end
    end

    always_comb begin
        tgt_l   = '0;
        tgt_r   = '0;
        state_d = state_q;
        lft_d   = lft_q;
        rght_d  = rght_q;
        if (state_q == S_RUN) begin
            tgt_l = dead_band(lft_cmd);
            tgt_r = dead_band(rght_cmd);
        end
        slew_l = slew(lft_q, tgt_l);
        slew_r = slew(rght_q, tgt_r);

        // Fault overrides everything and zeroes the outputs without waiting for a tick.
        if (flt) begin
            state_d = S_FAULT;
            lft_d   = '0;
            rght_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    lft_d  = '0;
                    rght_d = '0;
                    if (pwr_up) state_d = S_RUN;
                end
                S_RUN: begin
                    if (tick) begin
                        lft_d  = slew_l;
                        rght_d = slew_r;
                    end
                    if (!pwr_up) state_d = S_STOP;
                end
                S_STOP: begin
                    if (tick) begin
                        lft_d  = slew_l;
                        rght_d = slew_r;
                    end
                    if (pwr_up)
                        state_d = S_RUN;
                    else if (tick && (slew_l == 12'sd0) && (slew_r == 12'sd0))
                        state_d = S_IDLE;
                end
                default: begin
                    lft_d  = '0;
                    rght_d = '0;
                    if (flt_clr) state_d = S_IDLE;
                end
            endcase
        end
    end

    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;
    assign ramping  = (lft_q != tgt_l) | (rght_q != tgt_r);
    assign faulted  = (state_q == S_FAULT);

endmodule

// File: tb/tb_mtr_spd_ramp.sv
// Bench for mtr_spd_ramp: cycle-level behavioural model plus directed ramps.
module tb_mtr_spd_ramp;
    localparam int STEP = 16;
    localparam int UPD  = 8;
    localparam int DB   = 32;

    logic clk = 1'b0, rst = 1'b1, pwr_up = 1'b0, flt = 1'b0, flt_clr = 1'b0;
    logic signed [11:0] lft_cmd = '0, rght_cmd = '0;
    logic signed [11:0] lft_spd, rght_spd;
    logic ramping, faulted;

    int errors = 0, checks = 0;

    mtr_spd_ramp #(.STEP(STEP), .UPD_DIV(UPD), .DEADBAND(DB)) dut (
        .clk(clk), .rst(rst), .pwr_up(pwr_up), .lft_cmd(lft_cmd), .rght_cmd(rght_cmd),
        .flt(flt), .flt_clr(flt_clr), .lft_spd(lft_spd), .rght_spd(rght_spd),
        .ramping(ramping), .faulted(faulted));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: modes 0=idle 1=run 2=stop 3=fault, speeds as plain integers.
    int m_cnt = 0, m_st = 0, m_l = 0, m_r = 0, m_ticks = 0;

    function automatic int shape(input int c);
`ifdef MTR_SPD_DEADBAND_EN
        if (((c < 0) ? -c - 1 : c) < DB) return 0;
`endif
        return c;
    endfunction

    function automatic int approach(input int cur, input int tgt);
        if (tgt > cur) return (tgt - cur > STEP) ? cur + STEP : tgt;
        return (cur - tgt > STEP) ? cur - STEP : tgt;
    endfunction

    function automatic int tgt_of(input int cmd);
        return (m_st == 1) ? shape(cmd) : 0;
    endfunction

    always @(posedge clk or posedge rst) begin : mdl
        bit tk;
        int tl, tr;
        if (rst) begin
            m_cnt = 0; m_st = 0; m_l = 0; m_r = 0;
        end else begin
            tk = (m_cnt == UPD - 1);
            m_cnt = (m_cnt + 1) % UPD;
            if (tk) m_ticks++;
            tl = tgt_of(int'(lft_cmd));
            tr = tgt_of(int'(rght_cmd));
            if (flt) begin
                m_st = 3; m_l = 0; m_r = 0;
            end else if (m_st == 0) begin
                if (pwr_up) m_st = 1;
            end else if (m_st == 3) begin
                if (flt_clr) m_st = 0;
            end else begin
                if (tk) begin
                    m_l = approach(m_l, tl);
                    m_r = approach(m_r, tr);
                end
                if (m_st == 1) begin
                    if (!pwr_up) m_st = 2;
                end else if (pwr_up) m_st = 1;
                else if (tk && m_l == 0 && m_r == 0) m_st = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("mdl_lft_spd", int'(lft_spd), m_l);
        check("mdl_rght_spd", int'(rght_spd), m_r);
        check("mdl_ramping", int'(ramping),
              ((m_l != tgt_of(int'(lft_cmd))) || (m_r != tgt_of(int'(rght_cmd)))) ? 1 : 0);
        check("mdl_faulted", int'(faulted), (m_st == 3) ? 1 : 0);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_tick();
        int start = m_ticks;
        int k = 0;
        while (m_ticks == start && k < 3 * UPD) begin
            @(negedge clk);
            k++;
        end
        #1;
        if (m_ticks == start) check("tick_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_lft", int'(lft_spd), 0);
        check("async_rst_rght", int'(rght_spd), 0);
        check("async_rst_faulted", int'(faulted), 0);
        #1 rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int e;
        int exp_up[7] = '{16, 32, 48, 64, 80, 96, 100};
        cyc(2);
        rst = 1'b0;
        check("rst_lft", int'(lft_spd), 0);
        check("rst_rght", int'(rght_spd), 0);
        check("rst_ramping", int'(ramping), 0);
        check("rst_faulted", int'(faulted), 0);

        // Basic ramp to +100, then through zero to -100 and back to 0.
        pwr_up = 1'b1; lft_cmd = 12'sd100;
        foreach (exp_up[i]) begin
            wait_tick();
            check("up100_lft", int'(lft_spd), exp_up[i]);
            check("up100_ramping", int'(ramping), (exp_up[i] != 100) ? 1 : 0);
        end
        lft_cmd = -12'sd100;
        e = 100;
        for (int i = 0; i < 13; i++) begin
            e = (e - 16 < -100) ? -100 : e - 16;
            wait_tick();
            check("sign_lft", int'(lft_spd), e);
        end
        check("sign_land", int'(lft_spd), -100);
        lft_cmd = '0;
        for (int i = 0; i < 7; i++) wait_tick();
        check("back_zero", int'(lft_spd), 0);

        // Small commands near zero.
        lft_cmd = 12'sd20;
        wait_tick();
`ifdef MTR_SPD_DEADBAND_EN
        check("db20_a", int'(lft_spd), 0);
        wait_tick();
        check("db20_b", int'(lft_spd), 0);
`else
        check("db20_a", int'(lft_spd), 16);
        wait_tick();
        check("db20_b", int'(lft_spd), 20);
`endif
        lft_cmd = '0;
        wait_tick();
        wait_tick();
        check("db_zero", int'(lft_spd), 0);
        lft_cmd = -12'sd40;
        wait_tick(); check("neg40_a", int'(lft_spd), -16);
        wait_tick(); check("neg40_b", int'(lft_spd), -32);
        wait_tick(); check("neg40_c", int'(lft_spd), -40);

        // Full-scale swing 2047 -> -2048.
        lft_cmd = 12'sd2047;
        for (int k = 0; k < 200 && lft_spd != 12'sd2047; k++) wait_tick();
        check("fs_top", int'(lft_spd), 2047);
        lft_cmd = -12'sd2048;
        e = 2047;
        for (int i = 0; i < 256; i++) begin
            e = (e - 16 < -2048) ? -2048 : e - 16;
            wait_tick();
            check("fs_down", int'(lft_spd), e);
        end
        check("fs_bottom", int'(lft_spd), -2048);
        check("fs_ramping", int'(ramping), 0);

        // Power-down ramp to zero, then resume mid-ramp.
        do_reset();
        lft_cmd = '0; rght_cmd = 12'sd200; pwr_up = 1'b1;
        for (int i = 0; i < 13; i++) wait_tick();
        check("stop_top", int'(rght_spd), 200);
        pwr_up = 1'b0;
        e = 200;
        for (int i = 0; i < 13; i++) begin
            e = (e - 16 < 0) ? 0 : e - 16;
            wait_tick();
            check("stop_down", int'(rght_spd), e);
        end
        check("stop_ramping", int'(ramping), 0);
        cyc(3);
        pwr_up = 1'b1;
        for (int i = 0; i < 13; i++) wait_tick();
        pwr_up = 1'b0;
        for (int i = 0; i < 6; i++) wait_tick();
        check("stop_104", int'(rght_spd), 104);
        pwr_up = 1'b1;
        wait_tick(); check("resume_120", int'(rght_spd), 120);
        check("resume_ramping", int'(ramping), 1);
        wait_tick(); check("resume_136", int'(rght_spd), 136);

        // Fault entry off-tick and clear handshake.
        do_reset();
        rght_cmd = '0; lft_cmd = 12'sd100; pwr_up = 1'b1;
        for (int i = 0; i < 3; i++) wait_tick();
        check("flt_pre", int'(lft_spd), 48);
        flt = 1'b1;
        cyc(1);
        check("flt_lft", int'(lft_spd), 0);
        check("flt_faulted", int'(faulted), 1);
        flt_clr = 1'b1; cyc(1); flt_clr = 1'b0;
        check("flt_clr_ignored", int'(faulted), 1);
        flt = 1'b0; cyc(2);
        check("flt_held", int'(faulted), 1);
        flt_clr = 1'b1; cyc(1); flt_clr = 1'b0;
        check("flt_cleared", int'(faulted), 0);
        wait_tick(); check("post_flt_16", int'(lft_spd), 16);

        // Asynchronous reset mid-interval; tick counter restarts.
        for (int i = 0; i < 3; i++) wait_tick();
        check("ar_pre", int'(lft_spd), 64);
        cyc(3);
        rst = 1'b1;
        #1;
        check("ar_lft_now", int'(lft_spd), 0);
        check("ar_ramping", int'(ramping), 0);
        #1 rst = 1'b0;
        cyc(7);
        check("ar_before_tick", int'(lft_spd), 0);
        cyc(1);
        check("ar_first_tick", int'(lft_spd), 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
